// File: rtl/param_writer_pkg.sv
// rtl/param_writer_pkg.sv - shared types, widths and clamp helper for param_writer
//
// Purpose : Values are two's-complement Q7.24 (32 bits total, 24 fraction
//           bits). Holds the data width, the FSM state encoding and the
//           saturation helper used by each parameter slot.
// Ports   : none (package).
package param_writer_pkg;

   localparam int N_BITS = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Signed saturation to [-lim, +lim]. When en is low the value passes
   // through untouched, so the same call site serves both build flavours.
   function automatic logic [N_BITS-1:0] sat_clamp(
      input logic [N_BITS-1:0] d,
      input logic [N_BITS-1:0] lim,
      input logic              en
   );
      logic signed [N_BITS-1:0] s_d;
      logic signed [N_BITS-1:0] s_pos;
      logic signed [N_BITS-1:0] s_neg;
      s_d   = signed'(d);
      s_pos = signed'(lim);
      s_neg = -s_pos;
      if (en && (s_d > s_pos)) begin
         return lim;
      end
      if (en && (s_d < s_neg)) begin
         return s_neg;
      end
      return d;
   endfunction

endpackage

// File: rtl/param_writer_if.sv
// rtl/param_writer_if.sv - sample handshake, backprop enables and parameter buses
//
// Purpose : Groups every non-clock signal of param_writer.
// Signals : sample_valid/sample_ready - one handshake per training sample
//           we      [WT+ND]  - write enables towards backprop
//           dtb              - 0 accumulate, 1 drain to bus
//           bus     [2*N]    - shared bus, low N bits carry the updated value
//           wall    [N*WT]   - weights, slot k at [k*N +: N]
//           ball    [N*ND]   - biases,  slot k at [k*N +: N]
//           acc_clr          - one-cycle accumulator clear after a drain
//           busy             - high while draining or finishing
//           epoch   [16]     - completed update count
// Modports: slave (param_writer side), master (upstream / bench side).
interface param_writer_if #(
   parameter int WT = 12,
   parameter int ND = 5
);
   import param_writer_pkg::*;

   logic                   sample_valid;
   logic                   sample_ready;
   logic [WT+ND-1:0]       we;
   logic                   dtb;
   logic [2*N_BITS-1:0]    bus;
   logic [N_BITS*WT-1:0]   wall;
   logic [N_BITS*ND-1:0]   ball;
   logic                   acc_clr;
   logic                   busy;
   logic [15:0]            epoch;

   modport slave (
      input  sample_valid, bus,
      output sample_ready, we, dtb, wall, ball, acc_clr, busy, epoch
   );

   modport master (
      output sample_valid, bus,
      input  sample_ready, we, dtb, wall, ball, acc_clr, busy, epoch
   );

endinterface

// File: rtl/param_slot.sv
// rtl/param_slot.sv - one N-bit parameter register with load enable and optional clamp
//
// Purpose : Stores a single weight or bias. Loads i_d on i_load; returns to
//           RESET_VAL on asynchronous reset. With PARAM_WRITER_CLAMP_EN
//           defined the loaded value is saturated to [-CLAMP, +CLAMP].
// Ports   : clk, rst (async, active high), i_load, i_d[N], o_q[N].
module param_slot
   import param_writer_pkg::*;
#(
   parameter logic [N_BITS-1:0] RESET_VAL = '0,
   parameter logic [N_BITS-1:0] CLAMP     = 32'h7F000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic [N_BITS-1:0] i_d,
   output logic [N_BITS-1:0] o_q
);

`ifdef PARAM_WRITER_CLAMP_EN
   localparam logic CLAMP_ON = 1'b1;
`else
   localparam logic CLAMP_ON = 1'b0;
`endif

   logic [N_BITS-1:0] r_q;
   logic [N_BITS-1:0] w_d;

   assign w_d = sat_clamp(i_d, CLAMP, CLAMP_ON);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= RESET_VAL;
      end else if (i_load) begin
         r_q <= w_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/param_writer.sv
// rtl/param_writer.sv - batch sequencer and weight/bias store behind backprop
//
// Purpose : Accepts BATCH samples (all-ones write enable per sample so
//           backprop accumulates), then drains WT+ND updated values off the
//           shared bus with a one-hot select, pulses acc_clr and bumps epoch.
//           Optional saturation of stored values: PARAM_WRITER_CLAMP_EN.
// Ports   : clk, rst (async, active high), pw (param_writer_if.slave).
module param_writer
   import param_writer_pkg::*;
#(
   parameter int                WT     = 12,
   parameter int                ND     = 5,
   parameter int                BATCH  = 4,
   parameter logic [N_BITS-1:0] INIT_W = 32'h00800000,
   parameter logic [N_BITS-1:0] INIT_B = 32'hFF000000,
   parameter logic [N_BITS-1:0] CLAMP  = 32'h7F000000
) (
   input logic           clk,
   input logic           rst,
   param_writer_if.slave pw
);

   localparam int NS    = WT + ND;
   localparam int IDX_W = (NS > 1) ? $clog2(NS) : 1;
   localparam int CNT_W = $clog2(BATCH + 1);

   state_t              r_state;
   state_t              w_next_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [IDX_W-1:0]    r_idx;
   logic [15:0]         r_epoch;

   logic                w_accept;
   logic                w_last_sample;
   logic                w_last_slot;
   logic                w_ready;
   logic                w_dtb;
   logic                w_acc_clr;
   logic [NS-1:0]       w_we;
   logic [NS-1:0]       w_load;
   logic [N_BITS-1:0]   w_bus_lo;
   logic                w_unused_bus_hi;
   logic [N_BITS-1:0]   w_slot_q [NS];
   logic [N_BITS*WT-1:0] w_wall;
   logic [N_BITS*ND-1:0] w_ball;

   assign w_bus_lo        = pw.bus[N_BITS-1:0];
   assign w_unused_bus_hi = ^pw.bus[2*N_BITS-1:N_BITS];

   assign w_last_sample = (r_cnt == CNT_W'(BATCH - 1));
   assign w_last_slot   = (r_idx == IDX_W'(NS - 1));

   always_comb begin
      w_next_state = r_state;
      w_ready      = 1'b0;
      w_dtb        = 1'b0;
      w_acc_clr    = 1'b0;
      w_accept     = 1'b0;
      w_we         = '0;
      w_load       = '0;
      case (r_state)
         IDLE, ACCUM: begin
            w_ready = 1'b1;
            if (pw.sample_valid) begin
               w_accept     = 1'b1;
               w_we         = '1;
               w_next_state = w_last_sample ? DRAIN : ACCUM;
            end
         end
         DRAIN: begin
            // The select and the load strobe are the same one-hot vector:
            // the slot backprop is driving onto the bus is the one captured.
            w_dtb  = 1'b1;
            w_we   = NS'(1) << r_idx;
            w_load = NS'(1) << r_idx;
            if (w_last_slot) begin
               w_next_state = DONE;
            end
         end
         DONE: begin
            w_acc_clr    = 1'b1;
            w_next_state = IDLE;
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_epoch <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_accept) begin
            r_cnt <= w_last_sample ? '0 : r_cnt + CNT_W'(1);
         end
         if (r_state == DRAIN) begin
            r_idx <= w_last_slot ? '0 : r_idx + IDX_W'(1);
         end
         if (r_state == DONE) begin
            r_epoch <= r_epoch + 16'd1;
         end
      end
   end

   // Slots 0..WT-1 are weights, WT..NS-1 are biases.
   for (genvar k = 0; k < NS; k++) begin : g_slot
      param_slot #(
         .RESET_VAL ((k < WT) ? INIT_W : INIT_B),
         .CLAMP     (CLAMP)
      ) u_slot (
         .clk    (clk),
         .rst    (rst),
         .i_load (w_load[k]),
         .i_d    (w_bus_lo),
         .o_q    (w_slot_q[k])
      );
      if (k < WT) begin : g_w
         assign w_wall[k*N_BITS +: N_BITS] = w_slot_q[k];
      end else begin : g_b
         assign w_ball[(k-WT)*N_BITS +: N_BITS] = w_slot_q[k];
      end
   end

   assign pw.sample_ready = w_ready;
   assign pw.we           = w_we;
   assign pw.dtb          = w_dtb;
   assign pw.acc_clr      = w_acc_clr;
   assign pw.busy         = (r_state == DRAIN) || (r_state == DONE);
   assign pw.epoch        = r_epoch;
   assign pw.wall         = w_wall;
   assign pw.ball         = w_ball;

endmodule

// File: doc/param_writer.md
Name: param_writer

Overview:
- Sequencer and parameter store that sits directly downstream of the backprop stage.
- Accepts one handshake per training sample and, for each, drives an all-ones write-enable so backprop accumulates its deltas.
- After BATCH samples, raises dtb and walks a one-hot select across every weight/bias slot, capturing each updated value from the shared bus.
- Holds all weights and biases as flat vectors feeding the forward pass; pulses a clear for accumulators when the batch completes.

Parameters:
- WT, 12, total weights (wall slots).
- ND, 5, total non-input nodes (bias slots).
- BATCH, 4, samples accumulated per update; must be ≥1.
- INIT_W, 32'h00800000 (0.5 in Q7.24), reset value of every weight.
- INIT_B, 32'hFF000000 (-1.0), reset value of every bias.
- CLAMP, 32'h7F000000 (127.0), saturation magnitude; used only with PARAM_WRITER_CLAMP_EN.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- sample_valid  in  1  forward pass has stable outputs for one sample.
- sample_ready  out  1  block accepts a sample this cycle.
- we  out  WT+ND  enable vector to backprop.
- dtb  out  1  0 = accumulate phase, 1 = drain to bus.
- bus  in  2*n  shared bus; bits [n-1:0] carry the updated value.
- wall  out  n*WT  weights, slot k at [k*n +: n].
- ball  out  n*ND  biases, slot k at [k*n +: n].
- acc_clr  out  1  one-cycle pulse after drain completes.
- busy  out  1  high in DRAIN and DONE.
- epoch  out  16  count of completed updates; wraps at 65535→0.

Behaviour:
- Fixed point: n=`n (32), f=`f (24), i=`i (7), two's complement, taken from fixed_point.vh.
- Reset (async, any state):
  - state=IDLE, cnt=0, idx=0.
  - we=0, dtb=0, acc_clr=0, epoch=0.
  - All wall slots = INIT_W; all ball slots = INIT_B.
  - sample_ready=1.
- States: IDLE, ACCUM, DRAIN, DONE.
- IDLE / ACCUM:
  - sample_ready=1, dtb=0.
  - On sample_valid, the same cycle drives we=all ones (combinational, 1-cycle pulse) and cnt increments at the edge.
  - If the accepted sample brings cnt to BATCH, next state=DRAIN with cnt=0 and idx=0; otherwise ACCUM.
  - BATCH=1 goes straight to DRAIN after each sample.
- DRAIN:
  - sample_ready=0, dtb=1, we = one-hot at bit idx.
  - At each edge, capture bus[n-1:0] into slot idx:
    - idx<WT → wall[idx];
    - otherwise → ball[idx-WT].
  - idx increments each cycle.
  - Capture at idx=WT+ND-1 moves the FSM to DONE.
  - Duration is exactly WT+ND cycles; sample_valid is ignored (not queued).
- DONE (1 cycle):
  - dtb=0, we=0, acc_clr=1, epoch+1.
  - next state=IDLE; sample_ready=0 this cycle.
- Latency: the last accepted sample to the first dtb=1 cycle is 1 cycle; a full update is BATCH accepts + WT+ND+1 cycles.
- wall/ball are registered and change only on DRAIN captures or reset; a slot is updated on the edge that ends its select cycle.
- Reset mid-DRAIN: partially written slots revert to INIT values; no acc_clr pulse.
- bus high-Z/X on an unselected slot is never sampled.

Optional Feature:
- PARAM_WRITER_CLAMP_EN defined: a captured value above +CLAMP stores +CLAMP, and one below -CLAMP stores -CLAMP (signed compare on n bits).
- Undefined: the captured value is stored unmodified, and the CLAMP parameter is unused.

Decomposition:
- Shared: n/f/i macros from fixed_point.vh, plus state encoding localparams (IDLE=0, ACCUM=1, DRAIN=2, DONE=3) in a small include, param_writer_defs.vh.
- One natural sub-module, param_slot: a per-slot n-bit register with async reset value parameter, load enable, and optional clamp. It is instantiated WT+ND times in a generate loop.

Test Plan:
- Reset: hold rst for 3 cycles → wall all 0x00800000, ball all 0xFF000000, dtb=0, we=0, epoch=0, sample_ready=1.
- Accumulate: BATCH=4, 3 valid pulses → we=0x1FFFF for exactly 3 single cycles, state ACCUM, dtb never 1.
- Drain: 4th sample; bus drives 0x100+k in cycle k of DRAIN → dtb high 17 cycles, we one-hot 0x00001…0x10000 in order, wall[k]=0x100+k, ball[j]=0x10C+j, acc_clr single pulse, epoch=1.
- Stall: sample_valid held high through DRAIN → sample_ready=0, no extra we pulses, cnt still 0 on return to IDLE.
- Reset mid-drain: assert rst at DRAIN idx=6 → slots 0..5 back to INIT_W, state IDLE, no acc_clr.
- Clamp (macro on, CLAMP=0x02000000): bus=0x05000000 on slot 0, 0xF0000000 on slot 1 → wall[0]=0x02000000, wall[1]=0xFE000000; macro off → raw values stored.
